// File: rtl/stream_to_vga_sink.sv
// Pixel-stream to VGA raster bridge: FIFO-buffers an upstream
// pixel stream and aligns its frame markers to the vga_sync raster.
// Ports:
//   clk, reset      pixel clock, async active-low reset
//   pix_in, sof_in, valid_in, output_ready
//                   upstream stream (transfer = valid_in && output_ready)
//   hcount, vcount, visible
//                   raster position from vga_sync
//   pix_out, pix_out_valid
//                   registered pixel, or black fill when not valid
//   fifo_level      FIFO occupancy
//   underflow, misalign, err_count
//                   sticky error flags and saturating resync count
module stream_to_vga_sink #(
    parameter int DEPTH   = 16,
    parameter int PREFILL = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             pix_in,
    input  logic                   sof_in,
    input  logic                   valid_in,
    output logic                   output_ready,
    input  logic [9:0]             hcount,
    input  logic [9:0]             vcount,
    input  logic                   visible,
    output logic [7:0]             pix_out,
    output logic                   pix_out_valid,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   underflow,
    output logic                   misalign,
    output logic [7:0]             err_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] PRE_LVL  = LW'(PREFILL);

    typedef enum logic [1:0] {
        RESYNC,
        FILL,
        STREAM
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;

    logic       fs;
    logic       push;
    logic       wr_en;
    logic       pop;
    logic       flush;
    logic       ufl;
    logic       mis;
    logic [8:0] head;

    assign fs   = visible && (hcount == 10'd0) && (vcount == 10'd0);
    assign head = mem[rd_ptr];

    // RESYNC must keep draining upstream so stale beats are dropped
    assign output_ready = (state == RESYNC) || (level != FULL_LVL);
    assign push         = valid_in && output_ready;
    assign fifo_level   = level;

    always_comb begin
        wr_en      = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        ufl        = 1'b0;
        mis        = 1'b0;
        next_state = state;
        case (state)
            RESYNC: begin
                if (push && sof_in) begin
                    wr_en      = 1'b1;
                    next_state = FILL;
                end
            end
            FILL: begin
                wr_en = push;
                if (fs && (level >= PRE_LVL)) begin
                    pop        = 1'b1;
                    next_state = STREAM;
                end
            end
            STREAM: begin
                wr_en = push;
                if (visible) begin
                    if (level == '0) begin
                        ufl   = 1'b1;
                        flush = 1'b1;
                    end else if (head[8] != fs) begin
                        // frame marker and raster disagree
                        mis   = 1'b1;
                        flush = 1'b1;
                    end else begin
                        pop = 1'b1;
                    end
                end
                if (flush) begin
                    // flush wins over a same-cycle push
                    wr_en      = 1'b0;
                    next_state = RESYNC;
                end
            end
            default: next_state = RESYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {sof_in, pix_in};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= RESYNC;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            pix_out       <= 8'd0;
            pix_out_valid <= 1'b0;
            underflow     <= 1'b0;
            misalign      <= 1'b0;
            err_count     <= 8'd0;
        end else begin
            state         <= next_state;
            pix_out       <= pop ? head[7:0] : 8'd0;
            pix_out_valid <= pop;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                level <= level + LW'(wr_en) - LW'(pop);
            end
            if (ufl) begin
                underflow <= 1'b1;
            end
            if (mis) begin
                misalign <= 1'b1;
            end
            if ((ufl || mis) && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_stream_to_vga_sink.sv
// Scoreboard bench for stream_to_vga_sink on a reduced raster
// (16x4 total, 12x3 visible) so long scenarios stay short.
module tb_stream_to_vga_sink;

    localparam int H_TOT = 16;
    localparam int H_VIS = 12;
    localparam int V_TOT = 4;
    localparam int V_VIS = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] pix_in;
    logic       sof_in;
    logic       valid_in;
    logic       output_ready;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       visible;
    logic [7:0] pix_out;
    logic       pix_out_valid;
    logic [4:0] fifo_level;
    logic       underflow;
    logic       misalign;
    logic [7:0] err_count;

    typedef struct packed {
        logic       v;
        logic       sof;
        logic [7:0] pix;
    } beat_t;

    beat_t      script[$];
    logic [7:0] exp_q[$];
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    stream_to_vga_sink #(
        .DEPTH(16),
        .PREFILL(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pix_in(pix_in),
        .sof_in(sof_in),
        .valid_in(valid_in),
        .output_ready(output_ready),
        .hcount(hcount),
        .vcount(vcount),
        .visible(visible),
        .pix_out(pix_out),
        .pix_out_valid(pix_out_valid),
        .fifo_level(fifo_level),
        .underflow(underflow),
        .misalign(misalign),
        .err_count(err_count)
    );

    task automatic check(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    task automatic add_beat(logic s, logic [7:0] p, bit out);
        script.push_back({1'b1, s, p});
        if (out) exp_q.push_back(p);
    endtask

    task automatic add_idle(int n);
        repeat (n) script.push_back({1'b0, 1'b0, 8'd0});
    endtask

    function automatic logic [7:0] px(int f, int i);
        return 8'((f * 40 + i * 3) % 256);
    endfunction

    task automatic add_frame(int f, int n, int n_out);
        for (int i = 0; i < n; i++)
            add_beat(i == 0, px(f, i), i < n_out);
    endtask

    // raster generator standing in for vga_sync
    initial begin
        int h;
        int v;
        h = H_TOT - 1;
        v = V_TOT - 1;
        hcount = 10'd0;
        vcount = 10'd0;
        visible = 1'b0;
        forever begin
            @(negedge clk);
            if (h == H_TOT - 1) begin
                h = 0;
                v = (v == V_TOT - 1) ? 0 : v + 1;
            end else begin
                h++;
            end
            hcount = 10'(h);
            vcount = 10'(v);
            visible = (h < H_VIS) && (v < V_VIS);
        end
    end

    // upstream driver: a beat leaves the script once it will be taken
    initial begin
        beat_t b;
        valid_in = 1'b0;
        sof_in = 1'b0;
        pix_in = 8'd0;
        forever begin
            @(negedge clk);
            if (script.size() == 0) begin
                valid_in = 1'b0;
                sof_in = 1'b0;
            end else begin
                b = script[0];
                valid_in = b.v;
                sof_in = b.sof;
                pix_in = b.pix;
                if (!b.v || output_ready)
                    void'(script.pop_front());
            end
        end
    end

    // monitor
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                if (pix_out_valid) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_pixel: got %0d want none",
                                 pix_out);
                    end else begin
                        check("pixel", pix_out, exp_q.pop_front());
                    end
                end else begin
                    check("black_fill", pix_out, 0);
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", output_ready, 1);
        check("rst_level", fifo_level, 0);
        check("rst_valid", pix_out_valid, 0);
        check("rst_pix", pix_out, 0);
        check("rst_underflow", underflow, 0);
        check("rst_misalign", misalign, 0);
        check("rst_err", err_count, 0);
        reset = 1'b1;

        // beats before any sof are discarded
        for (int i = 0; i < 5; i++)
            add_beat(1'b0, 8'(100 + i), 1'b0);
        for (int i = 0; i < 100 && script.size() != 0; i++)
            @(negedge clk);
        repeat (3) @(negedge clk);
        check("presof_level", fifo_level, 0);
        check("presof_ready", output_ready, 1);
        check("presof_err", err_count, 0);

        add_frame(0, 36, 36);
        add_frame(1, 36, 36);
        // frame 2 stalls after 5 pixels
        add_frame(2, 5, 5);
        add_idle(250);
        add_frame(3, 36, 36);
        // frame 4 carries a stray sof at the start of row 1
        for (int i = 0; i < 12; i++)
            add_beat(i == 0, px(4, i), 1'b1);
        add_beat(1'b1, 8'd222, 1'b0);
        for (int i = 12; i < 36; i++)
            add_beat(1'b0, px(4, i), 1'b0);
        add_frame(5, 36, 36);
        // forced underflows
        for (int r = 0; r < 300; r++) begin
            for (int i = 0; i < 8; i++)
                add_beat(i == 0, 8'((r + i * 5) % 256), 1'b1);
            add_idle(150);
        end

        for (int i = 0; i < 3000 && !underflow; i++)
            @(negedge clk);
        check("uf_flag", underflow, 1);
        check("uf_err", err_count, 1);
        check("uf_misalign", misalign, 0);

        for (int i = 0; i < 3000 && fifo_level != 5'd16; i++)
            @(negedge clk);
        check("full_level", fifo_level, 16);
        check("full_ready", output_ready, 0);

        for (int i = 0; i < 3000 && !misalign; i++)
            @(negedge clk);
        check("mis_flag", misalign, 1);
        check("mis_err", err_count, 2);
        check("mis_underflow", underflow, 1);

        for (int i = 0; i < 60000 &&
             (script.size() != 0 || exp_q.size() != 0); i++)
            @(negedge clk);
        repeat (300) @(negedge clk);
        check("script_drained", script.size(), 0);
        check("all_pixels_out", exp_q.size(), 0);
        check("sat_err", err_count, 255);
        check("sat_underflow", underflow, 1);
        check("sat_misalign", misalign, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_to_vga_sink.md
STREAM_TO_VGA_SINK -- requirements
Module: stream_to_vga_sink

Interface
REQ-001 Parameter DEPTH, default 16: FIFO entries; power of two, range 4..256.
REQ-002 Parameter PREFILL, default 8: minimum FIFO level before streaming starts; range 1..DEPTH.
REQ-003 Clocking and reset are fixed: one clock, named clk; reset is asynchronous and active-low, named reset (asserted at 0).
REQ-004 clk  in  1  pixel clock, shared with vga_sync.
REQ-005 reset  in  1  asynchronous active-low reset.
REQ-006 pix_in  in  8  grayscale pixel from the upstream filter stage.
REQ-007 sof_in  in  1  marks pix_in as the first pixel of a frame; qualified by valid_in.
REQ-008 valid_in  in  1  upstream pixel valid.
REQ-009 output_ready  out  1  ready to the upstream stage; a transfer occurs when valid_in && output_ready.
REQ-010 hcount, vcount  in  10 each  raster position from vga_sync.
REQ-011 visible  in  1  active-video flag from vga_sync.
REQ-012 pix_out  out  8  registered pixel for VGA_R/G/B.
REQ-013 pix_out_valid  out  1  pix_out carries a real pixel, not black fill.
REQ-014 fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-015 underflow  out  1  sticky flag: FIFO ran empty during active video.
REQ-016 misalign  out  1  sticky flag: frame marker and raster position disagreed.
REQ-017 err_count  out  8  saturating count of resync events.

Function
REQ-018 FIFO: DEPTH x 9-bit entries holding {sof, pixel}; stores to RAM or registers; occupancy counter has one extra bit so full and empty are distinct.
REQ-019 Frame start (fs) is defined as visible && hcount==0 && vcount==0.
REQ-020 Pop condition: state STREAM && visible && level!=0; entries pop in write order.
REQ-021 Output latency is 1 cycle: pix_out and pix_out_valid are registered from the popped entry.
- Visible cycle with no pop: pix_out=0 and pix_out_valid=0 on the next cycle.
REQ-022 Push condition: valid_in && output_ready.
- output_ready = (level<DEPTH), except in RESYNC where output_ready=1.
- output_ready is driven from registered state only; it has no combinational path from valid_in.
REQ-023 Push and pop in the same cycle leave the level unchanged.
- When full, output_ready=0, so a push is impossible and a simultaneous pop only decrements.
REQ-024 The FSM has three states: RESYNC, FILL, STREAM.
REQ-025 RESYNC: accepted beats with sof_in=0 are discarded; the first accepted beat with sof_in=1 is written to the FIFO; next state FILL.
REQ-026 FILL: no pops.
- Move to STREAM on the cycle where fs && level>=PREFILL.
- The pop happens in that same fs cycle (fs pixel is output).
- If fs occurs with level<PREFILL, stay in FILL and wait for the next fs.
REQ-027 STREAM, underflow: visible with level==0 sets underflow, increments err_count, flushes the FIFO (level=0) and enters RESYNC.
REQ-028 STREAM, misalign: a pop whose entry has sof=1 without fs, or fs whose head entry has sof=0, sets misalign, increments err_count, flushes and enters RESYNC.
- The offending pixel is not output (pix_out_valid=0).
REQ-029 Flush and push in the same cycle: the flush wins; the pushed beat is handled by RESYNC rules on the following cycles only.
REQ-030 err_count saturates at 255 and never wraps.
REQ-031 Blanking (visible=0) never pops, in any state.

Reset
REQ-032 While reset=0, outputs take these values immediately (asynchronous):
- state RESYNC, level 0
- pix_out=0, pix_out_valid=0
- underflow=0, misalign=0, err_count=0
- output_ready=1 (RESYNC rule)
REQ-033 Reset deassertion mid-frame: the first frame after reset is discarded up to the next sof_in; no pixel is output before the following fs.
REQ-034 Flags and err_count clear only on reset.

Verification
REQ-035 The bench shall cover these directed scenarios:
- Reset, then a frame of 640x480 pixels (first sof_in=1, value=x mod 256), upstream always valid, PREFILL=8 -> first fs outputs pix_out=0 one cycle later with pix_out_valid=1; the line repeats 0..255 ramp; no flags set.
- Upstream stalls 20 cycles mid-line with DEPTH=16 -> underflow=1, err_count=1, pix_out_valid=0 for the rest of the frame; the next frame streams correctly after sof_in.
- Downstream in blanking, upstream valid continuously -> level reaches 16, output_ready=0, no beat lost; first visible pop returns the oldest pixel.
- Extra pixel inserted so sof=1 pops at hcount=0, vcount=1 -> misalign=1, RESYNC entered, err_count increments.
- Beats with sof_in=0 arrive before any sof_in after reset -> all discarded, level stays 0, output_ready=1.
- 300 forced underflows -> err_count holds at 255.
